// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner
// Two-channel push-button conditioner: synchronises each raw button, debounces
// it with a four-state press/release FSM, and turns every accepted press into
// a single one-clock pulse. A small arbiter keeps P1 and P2 from ever being
// high together by deferring P2 one cycle when both channels fire at once.
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1,
  input  logic btn2,
  output logic P1,
  output logic P2,
  output logic held1,
  output logic held2
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Terminal count: a level must be seen for DEBOUNCE_CYCLES consecutive
  // cycles, so the counter stops at DEBOUNCE_CYCLES-1 and never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit 0 is channel 1 (btn1), bit 1 is channel 2 (btn2).
  logic [1:0]       s1;
  logic [1:0]       s2;
  state_t           state     [2];
  state_t           state_nxt [2];
  logic [CNT_W-1:0] cnt       [2];
  logic [CNT_W-1:0] cnt_nxt   [2];
  logic [1:0]       fire;
  logic [1:0]       held_nxt;
  logic             pend2;

  // ---- stage: two-flop synchroniser, raw buttons -> s1 -> s2 ----
  // Two-flop synchroniser per button; everything downstream reads s2 only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {btn2, btn1};
      s2 <= s1;
    end
  end

  // ---- stage: debounce FSM + counter per channel ----
  // Per-channel state and debounce counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= IDLE;
        cnt[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= state_nxt[ch];
        cnt[ch]   <= cnt_nxt[ch];
      end
    end
  end

  // Next-state, counter and fire decode for both channels. fire is raised in
  // the cycle the press is accepted so the registered pulse lines up with the
  // registered held level on the same edge.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_nxt[ch] = state[ch];
      cnt_nxt[ch]   = cnt[ch];
      fire[ch]      = 1'b0;
      unique case (state[ch])
        IDLE: begin
          if (s2[ch]) begin
            state_nxt[ch] = WAIT_HIGH;
            cnt_nxt[ch]   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2[ch]) begin
            // Press bounce or glitch: start over.
            state_nxt[ch] = IDLE;
            cnt_nxt[ch]   = '0;
          end else if (cnt[ch] == CNT_LAST) begin
            state_nxt[ch] = PRESSED;
            cnt_nxt[ch]   = '0;
            fire[ch]      = 1'b1;
          end else begin
            cnt_nxt[ch] = cnt[ch] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2[ch]) begin
            state_nxt[ch] = WAIT_LOW;
            cnt_nxt[ch]   = '0;
          end
        end
        WAIT_LOW: begin
          if (s2[ch]) begin
            // Release bounce: still held, no new pulse.
            state_nxt[ch] = PRESSED;
            cnt_nxt[ch]   = '0;
          end else if (cnt[ch] == CNT_LAST) begin
            state_nxt[ch] = IDLE;
            cnt_nxt[ch]   = '0;
          end else begin
            cnt_nxt[ch] = cnt[ch] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[ch] = IDLE;
          cnt_nxt[ch]   = '0;
        end
      endcase
      held_nxt[ch] = (state_nxt[ch] == PRESSED) || (state_nxt[ch] == WAIT_LOW);
    end
  end

  // ---- stage: arbiter and registered outputs ----
  // Registered outputs. Channel 1 wins a tie; channel 2's pulse is parked in
  // pend2 for one cycle. A channel cannot fire on consecutive cycles, so a
  // pending P2 never collides with a fresh P1 or a fresh fire2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      P1    <= 1'b0;
      P2    <= 1'b0;
      pend2 <= 1'b0;
      held1 <= 1'b0;
      held2 <= 1'b0;
    end else begin
      P1    <= fire[0];
      P2    <= pend2 | (fire[1] & ~fire[0]);
      pend2 <= fire[0] & fire[1];
      held1 <= held_nxt[0];
      held2 <= held_nxt[1];
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with DEBOUNCE_CYCLES=4.
// Each table row gives the button levels driven before a clock edge and the
// expected {P1,P2,held1,held2} just after that edge.
module tb_button_pulse_conditioner;

  logic clk;
  logic reset;
  logic btn1;
  logic btn2;
  logic P1;
  logic P2;
  logic held1;
  logic held2;

  int checks   = 0;
  int failures = 0;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn1 (btn1),
    .btn2 (btn2),
    .P1   (P1),
    .P2   (P2),
    .held1(held1),
    .held2(held2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       b1;
    logic       b2;
    logic [3:0] exp;  // {P1,P2,held1,held2}
  } vec_t;

  vec_t vecs[$];

  function automatic void addn(input int n, input logic b1, input logic b2,
                               input logic p1, input logic p2,
                               input logic h1, input logic h2);
    vec_t v;
    v.b1  = b1;
    v.b2  = b2;
    v.exp = {p1, p2, h1, h2};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    checks++;
    if ({P1, P2, held1, held2} !== exp) begin
      failures++;
      $display("FAIL %s got {P1,P2,held1,held2}=%b want=%b at %0t",
               name, {P1, P2, held1, held2}, exp, $time);
    end
  endtask

  // Drive buttons, advance one edge, then sample 1 ns after it.
  task automatic step(input string name, input logic b1, input logic b2,
                      input logic [3:0] exp);
    btn1 = b1;
    btn2 = b2;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // P1 and P2 must never be high together.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (P1 && P2) begin
        failures++;
        $display("FAIL overlap got P1=%b P2=%b want not both 1 at %0t", P1, P2, $time);
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn1  = 1'b0;
    btn2  = 1'b0;

    // Clean press held 20 cycles, then release.
    addn(6,  1,0, 0,0,0,0);
    addn(1,  1,0, 1,0,1,0);
    addn(13, 1,0, 0,0,1,0);
    addn(6,  0,0, 0,0,1,0);
    addn(4,  0,0, 0,0,0,0);
    // Short glitch on btn2 (3 cycles).
    addn(3,  0,1, 0,0,0,0);
    addn(8,  0,0, 0,0,0,0);
    // Bouncy press 1,0,1,0 then held; pulse 6 edges after the final rise.
    addn(1,  1,0, 0,0,0,0);
    addn(1,  0,0, 0,0,0,0);
    addn(1,  1,0, 0,0,0,0);
    addn(1,  0,0, 0,0,0,0);
    addn(6,  1,0, 0,0,0,0);
    addn(1,  1,0, 1,0,1,0);
    addn(3,  1,0, 0,0,1,0);
    addn(6,  0,0, 0,0,1,0);
    addn(4,  0,0, 0,0,0,0);
    // Coincident press: P1 at edge 6, P2 deferred to edge 7.
    addn(6,  1,1, 0,0,0,0);
    addn(1,  1,1, 1,0,1,1);
    addn(1,  1,1, 0,1,1,1);
    addn(4,  1,1, 0,0,1,1);
    addn(6,  0,0, 0,0,1,1);
    addn(4,  0,0, 0,0,0,0);
    // Hold 50 cycles, release 20 cycles, press again: two pulses.
    addn(6,  1,0, 0,0,0,0);
    addn(1,  1,0, 1,0,1,0);
    addn(43, 1,0, 0,0,1,0);
    addn(6,  0,0, 0,0,1,0);
    addn(14, 0,0, 0,0,0,0);
    addn(6,  1,0, 0,0,0,0);
    addn(1,  1,0, 1,0,1,0);
    addn(3,  1,0, 0,0,1,0);
    addn(6,  0,0, 0,0,1,0);
    addn(4,  0,0, 0,0,0,0);

    // Asynchronous reset state.
    #1 reset = 1'b0;
    #1 check("reset_async", 4'b0000);
    @(posedge clk); #1;
    check("reset_held", 4'b0000);
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].b1, vecs[i].b2, vecs[i].exp);

    // Reset during WAIT_HIGH with cnt=2 (after edge 4), button kept held.
    for (int i = 0; i < 5; i++) step($sformatf("rmid_pre%0d", i), 1'b1, 1'b0, 4'b0000);
    #2 reset = 1'b0;
    #1 check("rmid_async", 4'b0000);
    for (int i = 0; i < 3; i++) step($sformatf("rmid_in%0d", i), 1'b1, 1'b0, 4'b0000);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("rmid_post%0d", i), 1'b1, 1'b0, 4'b0000);
    step("rmid_pulse", 1'b1, 1'b0, 4'b1010);
    for (int i = 0; i < 2; i++) step($sformatf("rmid_hold%0d", i), 1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 6; i++) step($sformatf("rmid_rel%0d", i), 1'b0, 1'b0, 4'b0010);
    for (int i = 0; i < 3; i++) step($sformatf("rmid_idle%0d", i), 1'b0, 1'b0, 4'b0000);

    // Reset with pend2 set: the deferred P2 must be dropped.
    for (int i = 0; i < 6; i++) step($sformatf("rpend_pre%0d", i), 1'b1, 1'b1, 4'b0000);
    step("rpend_p1", 1'b1, 1'b1, 4'b1011);
    #2 reset = 1'b0;
    #1 check("rpend_async", 4'b0000);
    for (int i = 0; i < 3; i++) step($sformatf("rpend_in%0d", i), 1'b1, 1'b1, 4'b0000);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("rpend_post%0d", i), 1'b1, 1'b1, 4'b0000);
    step("rpend_p1b", 1'b1, 1'b1, 4'b1011);
    step("rpend_p2b", 1'b1, 1'b1, 4'b0111);
    for (int i = 0; i < 2; i++) step($sformatf("rpend_hold%0d", i), 1'b1, 1'b1, 4'b0011);
    for (int i = 0; i < 6; i++) step($sformatf("rpend_rel%0d", i), 1'b0, 1'b0, 4'b0011);
    step("rpend_idle", 1'b0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_pulse_conditioner.md
# button_pulse_conditioner

Two-channel input conditioner that turns the raw, bouncing, asynchronous push-button signals into clean one-clock pulses on `P1` and `P2`. It sits directly upstream of the Moore sequence detector and drives that detector's `P1`/`P2` inputs. The detector therefore sees exactly one pulse per physical press, and never sees both pulses in the same cycle. Each channel has its own synchronizer, debounce counter and press/release state machine. A shared arbiter serialises coincident pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000 (10 ms at 100 MHz): consecutive stable cycles required to accept a press or a release. Legal range is 2 to 2^CNT_W.
- `CNT_W`, default 20: width of each debounce counter.
- `clk` input 1: the single clock. All flops are on its rising edge.
- `reset` input 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is sampled on `clk`.
- `btn1` input 1: raw button 1, asynchronous to `clk`, active-high.
- `btn2` input 1: raw button 2, asynchronous to `clk`, active-high.
- `P1` output 1: one-cycle pulse for each accepted press of `btn1`. Registered.
- `P2` output 1: one-cycle pulse for each accepted press of `btn2`. Registered.
- `held1` output 1: debounced level of `btn1`. Registered.
- `held2` output 1: debounced level of `btn2`. Registered.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer (`s1`, then `s2`). All logic downstream uses `s2` only.
- **Per-channel FSM states:** IDLE, WAIT_HIGH, PRESSED, WAIT_LOW. Each channel has a counter `cnt` of CNT_W bits.
  - **IDLE:** if `s2`=1, go to WAIT_HIGH with `cnt`=0. Otherwise stay.
  - **WAIT_HIGH:** if `s2`=0, go to IDLE with `cnt`=0 (glitch rejected). Else, if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED and raise an internal `fire` for one cycle. Else increment `cnt`.
  - **PRESSED:** if `s2`=0, go to WAIT_LOW with `cnt`=0. Otherwise stay. No further pulses while held.
  - **WAIT_LOW:** if `s2`=1, go to PRESSED with `cnt`=0 (release bounce rejected). Else, if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE. Else increment `cnt`.
- **Held outputs:** `held1` and `held2` are 1 in PRESSED and WAIT_LOW, and 0 in IDLE and WAIT_HIGH.
- **Arbiter:**
  - If `fire1` is set, then `P1`=1 on the next edge.
  - If `fire2` is set and `fire1` is not, then `P2`=1 on the next edge.
  - If both are set in the same cycle, `P1` is issued first. A `pend2` flag is set, and `P2` is issued on the following edge, after which `pend2` clears.
  - `P1` and `P2` are never high in the same cycle.
- **Counter width:** the counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- **Reset (any time, including mid-debounce or with `pend2` set):**
  - Both FSMs go to IDLE.
  - Counters, synchronizers and `pend2` are cleared.
  - `P1`, `P2`, `held1` and `held2` are 0.
- **Button held across reset release:** this is treated as a fresh press. It is debounced normally and produces one pulse.

## Timing
- **Reset values:** all four outputs are 0.
- **Press latency:** let edge 0 be the edge at which `s1` first captures 1, with the input stable from then on. Then:
  - `s2`=1 at edge 1.
  - The FSM enters WAIT_HIGH at edge 2.
  - `P1` (or `P2`) goes high at edge DEBOUNCE_CYCLES+2, and `held` goes high at the same edge.
  - The pulse lasts exactly one cycle.
- **Deferred pulse:** when both channels fire together, `P2` goes high one cycle later than stated above.
- **Release latency:** `held` falls DEBOUNCE_CYCLES+2 edges after `s1` first captures 0, provided the input stays low.
- **Glitch rejection:** a high or low excursion that `s2` holds for fewer than DEBOUNCE_CYCLES cycles produces no state change and no pulse.
- **Re-press timing:** the minimum spacing between two accepted presses on one channel is 2·DEBOUNCE_CYCLES+2 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press:** `btn1` goes 0→1 and is held for 20 cycles → `P1` is high for exactly 1 cycle at edge 6 after capture, `held1`=1 from edge 6, and `P2` stays 0 throughout.
- **Bouncy press:** `btn1` toggles 1,0,1,0 with 1-cycle widths, then holds high → exactly one `P1` pulse, arriving 6 edges after the final rise.
- **Short glitch:** `btn2` is high for 3 cycles, then low → no `P2` pulse and `held2` stays 0.
- **Coincident press:** `btn1` and `btn2` rise on the same edge and are held → `P1` is high at edge 6, `P2` is high at edge 7, and they never overlap.
- **Hold and release:** `btn1` is held for 50 cycles, released, then pressed again after 20 cycles → exactly two `P1` pulses. `held1` falls 6 edges after the release.
- **Reset mid-debounce:** `reset` is driven to 0 during WAIT_HIGH (`cnt`=2) and also with `pend2` set → all outputs go to 0 immediately and no pulse is emitted. After `reset` returns to 1 with the button still held, one pulse appears 6 edges after the first capture.
